otter_imm_pipe: RTL and testbench
=================================

// Module: otter_imm_pipe
// PURPOSE
//  Registered, parametrised immediate generator between fetch and decode.
//  Decodes the opcode and emits ONE selected, sign-/zero-extended immediate
//  plus its type code. Results pass through a DEPTH-entry FIFO with
//  valid/ready on both sides, so the fetch stage can stall independently.
//  Supports RV32/RV64 immediates and a passthrough tag (PC/ROB id).
// PARAMETERS
//  XLEN   32  immediate width; 32 or 64; extension fills bits XLEN-1:32
//  DEPTH  2   FIFO entries; power of two, >=2
//  TAG_W  32  width of in_tag/out_tag passthrough
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous clear of all FIFO entries
//  in_valid   in   1      in_instrn/in_tag valid
//  in_ready   out  1      FIFO not full; accept when in_valid&in_ready
//  in_instrn  in   32     instruction word
//  in_tag     in   TAG_W  opaque tag, returned with the result
//  out_valid  out  1      FIFO head valid
//  out_ready  in   1      consumer takes head when out_valid&out_ready
//  out_imm    out  XLEN   immediate of head entry
//  out_type   out  3      0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z
//  out_tag    out  TAG_W  tag of head entry
//  out_illegal out 1      only with OTTER_IMM_ILLEGAL_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Opcode map [6:0]: 0110111/0010111->U; 1101111->J; 1100111,0000011,
//    0010011,0011011(RV64 only)->I; 0100011->S; 1100011->B;
//    1110011 with funct3[2]=1 ->Z; 1110011 with funct3[2]=0 ->NONE; else NONE.
//  - I={sx(i[31:20])}; S={sx(i[31:25],i[11:7])}; B={sx(i[31],i[7],
//    i[30:25],i[11:8]),0}; U={sx(i[31:12]),12'd0}; J={sx(i[31],i[19:12],
//    i[20],i[30:21]),0}; Z={zx(i[19:15])}; NONE=0. sx=sign-extend to XLEN
//    from i[31]; U is sign-extended above bit 31 when XLEN=64.
//  - Latency: entry accepted at edge N is visible on out_* after edge N
//    (out_valid=1 in cycle N+1) if FIFO was empty. Throughput 1/cycle.
//  - in_ready = (count<DEPTH); no combinational path from out_ready.
//  - Push and pop in the same cycle: count unchanged, order preserved.
//  - Empty: out_valid=0, out_imm=0, out_type=0, out_tag=0.
//  - Full: in_ready=0; in_valid ignored; out_* stable until popped.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - flush: next cycle count=0, out_valid=0, in_ready=1; a push in the
//    flush cycle is discarded. Flush has priority over push/pop.
//  - rst (any time, async): count=0, pointers=0, out_valid=0,
//    in_ready=1 while rst released, all out_* data=0. Entries lost.
//  - Output stability: while out_valid&!out_ready, out_* must not change.
// CONFIGURATION
//  OTTER_IMM_ILLEGAL_EN defined: out_illegal present, stored per entry;
//   1 when in_instrn[1:0]!=2'b11 or opcode not in map; such entries get
//   type NONE, imm 0. Reset/empty value 0.
//  Undefined: no out_illegal port; unknown opcodes silently NONE/0.
// TESTING
//  1 I-type: 32'hFFF00093 (addi x1,x0,-1) -> out_imm=all ones, type 1, 1cy.
//  2 B-type: 32'hFE000EE3 -> out_imm=-4 (XLEN'hFF..FC), type 3; J-type
//    32'h0080006F -> imm 8, type 5; Z: 32'h3400D073 -> imm 1, type 6.
//  3 XLEN=64 U: 32'h800002B7 -> out_imm=64'hFFFFFFFF80000000, type 4.
//  4 Backpressure: out_ready=0, push 3 words, DEPTH=2 -> in_ready=0 after
//    2 accepts; release -> both drained in order, tags match, no loss.
//  5 Simultaneous push/pop at count=1 for 10 cycles -> count stays 1,
//    outputs in order; then flush -> out_valid=0 next cycle.
//  6 Assert rst with 2 entries -> out_valid=0 immediately (async),
//    in_ready=1 after release; ILLEGAL_EN: 32'h00000000 -> out_illegal=1.

Source files
------------

// File: rtl/otter_imm_pipe_if.sv
// ----------------------------------------------------------------------------
// otter_imm_pipe_if
// Handshake bundle between the fetch stage (master) and the immediate
// generator FIFO (slave).
//   in_valid/in_ready/in_instrn/in_tag : request side, fetch -> generator
//   out_valid/out_ready/out_imm/out_type/out_tag : result side, head entry
//   out_illegal : per-entry illegal flag, present only when
//                 OTTER_IMM_ILLEGAL_EN is defined
// ----------------------------------------------------------------------------
interface otter_imm_pipe_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instrn;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_type;
   logic [TAG_W-1:0] out_tag;
`ifdef OTTER_IMM_ILLEGAL_EN
   logic             out_illegal;

   modport master (
      output in_valid, in_instrn, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_type, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_instrn, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_type, out_tag, out_illegal
   );
`else
   modport master (
      output in_valid, in_instrn, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_type, out_tag
   );

   modport slave (
      input  in_valid, in_instrn, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_type, out_tag
   );
`endif
endinterface

// File: rtl/otter_imm_pipe.sv
// ----------------------------------------------------------------------------
// otter_imm_pipe
// Immediate generator between fetch and decode. Decodes the opcode of each
// accepted instruction, forms one sign-/zero-extended immediate plus a type
// code (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z) and queues the result with the
// caller's tag in a DEPTH-entry FIFO.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, drops all entries
//   flush : synchronous clear of all entries, wins over push/pop
//   bus   : otter_imm_pipe_if.slave, request and result handshakes
// Parameters: XLEN (32/64), DEPTH (power of two, >= 2), TAG_W.
// Optional feature: define OTTER_IMM_ILLEGAL_EN to store and present
// out_illegal for words with in_instrn[1:0] != 2'b11 or an unmapped opcode.
// ----------------------------------------------------------------------------
module otter_imm_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   otter_imm_pipe_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   localparam logic [2:0] TyNone = 3'd0;
   localparam logic [2:0] TyI    = 3'd1;
   localparam logic [2:0] TyS    = 3'd2;
   localparam logic [2:0] TyB    = 3'd3;
   localparam logic [2:0] TyU    = 3'd4;
   localparam logic [2:0] TyJ    = 3'd5;
   localparam logic [2:0] TyZ    = 3'd6;

   logic [31:0]     w_instr;
   logic [2:0]      w_type;
   logic            w_known;
   logic            w_illegal;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic            w_push;
   logic            w_pop;
   logic            w_empty;

   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;

   logic [XLEN-1:0]  r_imm_mem  [DEPTH];
   logic [2:0]       r_type_mem [DEPTH];
   logic [TAG_W-1:0] r_tag_mem  [DEPTH];
`ifdef OTTER_IMM_ILLEGAL_EN
   logic             r_ill_mem  [DEPTH];
`endif

   assign w_instr = bus.in_instrn;

   // Opcode decode. Unmapped words fall back to NONE in both builds; the
   // illegal flag is only stored when the feature is enabled.
   always_comb begin
      w_type  = TyNone;
      w_known = 1'b1;
      case (w_instr[6:0])
         7'b0110111, 7'b0010111:            w_type = TyU;
         7'b1101111:                        w_type = TyJ;
         7'b1100111, 7'b0000011, 7'b0010011: w_type = TyI;
         7'b0011011: begin
            // OP-IMM-32 only exists on RV64
            if (XLEN == 64) w_type = TyI;
            else            w_known = 1'b0;
         end
         7'b0100011:                        w_type = TyS;
         7'b1100011:                        w_type = TyB;
         7'b1110011:                        w_type = w_instr[14] ? TyZ : TyNone;
         default:                           w_known = 1'b0;
      endcase
      w_illegal = !w_known || (w_instr[1:0] != 2'b11);
      if (w_illegal) w_type = TyNone;
   end

   // Immediates are formed at 32 bits; every 32-bit form is already correctly
   // signed in bit 31 (Z has bit 31 clear), so one sign extension covers RV64.
   always_comb begin
      case (w_type)
         TyI:     w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         TyS:     w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         TyB:     w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                             w_instr[11:8], 1'b0};
         TyU:     w_imm32 = {w_instr[31:12], 12'd0};
         TyJ:     w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                             w_instr[30:21], 1'b0};
         TyZ:     w_imm32 = {27'd0, w_instr[19:15]};
         default: w_imm32 = 32'd0;
      endcase
   end

   if (XLEN > 32) begin : g_ext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
   end else begin : g_noext
      assign w_imm = w_imm32;
   end

   // in_ready depends only on the registered count, never on out_ready
   assign bus.in_ready = (r_count < CntFull);
   assign w_empty      = (r_count == '0);
   assign w_push       = bus.in_valid && bus.in_ready;
   assign w_pop        = !w_empty && bus.out_ready;

   // Storage needs no reset: empty entries are masked at the output
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_imm_mem[r_wr_ptr]  <= w_imm;
         r_type_mem[r_wr_ptr] <= w_type;
         r_tag_mem[r_wr_ptr]  <= bus.in_tag;
`ifdef OTTER_IMM_ILLEGAL_EN
         r_ill_mem[r_wr_ptr]  <= w_illegal;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      end
   end

   assign bus.out_valid = !w_empty;
   assign bus.out_imm   = w_empty ? '0 : r_imm_mem[r_rd_ptr];
   assign bus.out_type  = w_empty ? '0 : r_type_mem[r_rd_ptr];
   assign bus.out_tag   = w_empty ? '0 : r_tag_mem[r_rd_ptr];
`ifdef OTTER_IMM_ILLEGAL_EN
   assign bus.out_illegal = w_empty ? 1'b0 : r_ill_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_otter_imm_pipe.sv
// ----------------------------------------------------------------------------
// tb_otter_imm_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus. Accepted
// requests enqueue the reference result; a negedge monitor pops and compares
// whenever an instance hands over its head entry.
// ----------------------------------------------------------------------------
module tb_otter_imm_pipe;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned TAG_W = 32;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic [31:0] tag;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        d_valid;
   logic        d_ready;
   logic [31:0] d_instr;
   logic [31:0] d_tag;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q32 [$];
   exp_t q64 [$];
   logic hold [2];
   exp_t held [2];
   logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h23,
                            7'h63, 7'h73};
   logic [31:0] dir_words [6] = '{32'hFE000EE3, 32'h0080006F, 32'h3400D073, 32'h800002B7,
                                  32'h0000001B, 32'hFFF00093};

   always #5 clk = ~clk;

   otter_imm_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
   otter_imm_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

   assign bus32.in_valid  = d_valid;
   assign bus32.in_instrn = d_instr;
   assign bus32.in_tag    = d_tag;
   assign bus32.out_ready = d_ready;
   assign bus64.in_valid  = d_valid;
   assign bus64.in_instrn = d_instr;
   assign bus64.in_tag    = d_tag;
   assign bus64.out_ready = d_ready;

   otter_imm_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus32));
   otter_imm_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus64));

   logic ill32, ill64;
`ifdef OTTER_IMM_ILLEGAL_EN
   assign ill32 = bus32.out_illegal;
   assign ill64 = bus64.out_illegal;
`else
   assign ill32 = 1'b0;
   assign ill64 = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: immediates built with signed arithmetic on the whole word
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] tag, input bit rv64);
      exp_t   e;
      longint sw;
      longint imm;
      int     typ;
      bit     known;
      sw    = longint'($signed(w));
      imm   = 0;
      typ   = 0;
      known = 1'b1;
      case (w[6:0])
         7'h37, 7'h17: begin typ = 4; imm = (sw >>> 12) <<< 12; end
         7'h6F: begin
            typ = 5;
            imm = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                  (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
         end
         7'h67, 7'h03, 7'h13: begin typ = 1; imm = sw >>> 20; end
         7'h1B: begin
            if (rv64) begin typ = 1; imm = sw >>> 20; end
            else known = 1'b0;
         end
         7'h23: begin typ = 2; imm = ((sw >>> 25) <<< 5) | longint'(w[11:7]); end
         7'h63: begin
            typ = 3;
            imm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                  (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
         end
         7'h73: if (w[14]) begin typ = 6; imm = longint'(w[19:15]); end
         default: known = 1'b0;
      endcase
      e.ill = !known || (w[1:0] != 2'b11);
      if (e.ill) begin typ = 0; imm = 0; end
      e.imm = 64'(imm);
      e.typ = 3'(typ);
      e.tag = tag;
      return e;
   endfunction

   task automatic sb_step(input int k, input logic ov, input logic ir, input logic [63:0] imm,
                          input logic [2:0] typ, input logic [31:0] tag, input logic ill);
      exp_t        e;
      logic [63:0] m;
      string       s;
      m = (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      s = (k == 0) ? "x32" : "x64";
      if (hold[k]) begin
         chk({s, "_stable_imm"}, imm, held[k].imm);
         chk({s, "_stable_tag"}, {32'd0, tag}, {32'd0, held[k].tag});
         chk({s, "_stable_type"}, {61'd0, typ}, {61'd0, held[k].typ});
      end
      if (!ov) begin
         chk({s, "_empty_out"}, imm | {29'd0, typ, tag}, 64'd0);
      end else if (d_ready) begin
         if ((k == 0 && q32.size() == 0) || (k == 1 && q64.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_pop actual_tag=%h required=none", s, tag);
         end else begin
            e = (k == 0) ? q32.pop_front() : q64.pop_front();
            chk({s, "_imm"}, imm & m, e.imm & m);
            chk({s, "_type"}, {61'd0, typ}, {61'd0, e.typ});
            chk({s, "_tag"}, {32'd0, tag}, {32'd0, e.tag});
`ifdef OTTER_IMM_ILLEGAL_EN
            chk({s, "_illegal"}, {63'd0, ill}, {63'd0, e.ill});
`endif
         end
      end
      hold[k] = ov && !d_ready && !flush;
      held[k] = '{imm: imm, typ: typ, tag: tag, ill: ill};
      if (flush) begin
         if (k == 0) q32.delete(); else q64.delete();
      end else if (d_valid && ir) begin
         if (k == 0) q32.push_back(model(d_instr, d_tag, 1'b0));
         else        q64.push_back(model(d_instr, d_tag, 1'b1));
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q32.delete();
         q64.delete();
         hold[0] = 1'b0;
         hold[1] = 1'b0;
      end else begin
         sb_step(0, bus32.out_valid, bus32.in_ready, {32'd0, bus32.out_imm}, bus32.out_type,
                 bus32.out_tag, ill32);
         sb_step(1, bus64.out_valid, bus64.in_ready, bus64.out_imm, bus64.out_type,
                 bus64.out_tag, ill64);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] w, input logic [31:0] t);
      d_valid = 1'b1;
      d_instr = w;
      d_tag   = t;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; d_valid = 1'b0; d_ready = 1'b0;
      d_instr = '0; d_tag = '0;
      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("rst_valid32", {63'd0, bus32.out_valid}, 64'd0);
      chk("rst_ready64", {63'd0, bus64.in_ready}, 64'd1);
      chk("rst_imm64", bus64.out_imm, 64'd0);

      // Single I-type, one-cycle latency
      d_ready = 1'b1;
      offer(32'hFFF00093, 32'd1);
      step();
      d_valid = 1'b0;
      chk("lat_valid32", {63'd0, bus32.out_valid}, 64'd1);
      chk("lat_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("lat_type32", {61'd0, bus32.out_type}, 64'd1);
      step();

      // Directed B/J/Z/U/RV64-only words, back to back
      for (int i = 0; i < 6; i++) begin
         offer(dir_words[i], 32'd10 + 32'(i));
         step();
      end
      d_valid = 1'b0;
      repeat (2) step();

      // U-type sign extension above bit 31
      offer(32'h800002B7, 32'd5);
      step();
      d_valid = 1'b0;
      chk("u_imm64", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
      chk("u_imm32", {32'd0, bus32.out_imm}, 64'h0000_0000_8000_0000);
      chk("u_type64", {61'd0, bus64.out_type}, 64'd4);
      step();

      // Backpressure: third word offered while full is ignored
      d_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(rand_word(), 32'd20 + 32'(i));
         step();
         if (i >= 1) chk("full_ready32", {63'd0, bus32.in_ready}, 64'd0);
      end
      d_valid = 1'b0;
      chk("full_valid64", {63'd0, bus64.out_valid}, 64'd1);
      d_ready = 1'b1;
      repeat (2) step();
      chk("drain_valid32", {63'd0, bus32.out_valid}, 64'd0);

      // Simultaneous push/pop at count=1, then flush
      d_ready = 1'b0;
      offer(rand_word(), 32'd30);
      step();
      d_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         offer(rand_word(), 32'd31 + 32'(i));
         step();
         chk("pp_ready32", {63'd0, bus32.in_ready}, 64'd1);
         chk("pp_valid64", {63'd0, bus64.out_valid}, 64'd1);
      end
      flush = 1'b1;
      offer(rand_word(), 32'd99);
      step();
      flush = 1'b0;
      d_valid = 1'b0;
      chk("flush_valid32", {63'd0, bus32.out_valid}, 64'd0);
      chk("flush_ready64", {63'd0, bus64.in_ready}, 64'd1);
      step();

      // Async reset with two entries queued
      d_ready = 1'b0;
      offer(rand_word(), 32'd50);
      step();
      offer(rand_word(), 32'd51);
      step();
      d_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid32", {63'd0, bus32.out_valid}, 64'd0);
      chk("arst_valid64", {63'd0, bus64.out_valid}, 64'd0);
      step();
      rst = 1'b0;
      #1;
      chk("arst_ready32", {63'd0, bus32.in_ready}, 64'd1);
      step();

      // All-zero word is outside the map
      offer(32'h0000_0000, 32'd77);
      step();
      d_valid = 1'b0;
      chk("zero_type64", {61'd0, bus64.out_type}, 64'd0);
`ifdef OTTER_IMM_ILLEGAL_EN
      chk("zero_illegal32", {63'd0, ill32}, 64'd1);
      chk("zero_illegal64", {63'd0, ill64}, 64'd1);
`endif
      d_ready = 1'b1;
      step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         d_valid = ($urandom_range(0, 3) != 0);
         d_instr = rand_word();
         d_tag   = $urandom;
         d_ready = ($urandom_range(0, 2) != 0);
         flush   = ($urandom_range(0, 39) == 0);
         step();
      end
      flush   = 1'b0;
      d_valid = 1'b0;
      d_ready = 1'b1;
      repeat (DEPTH + 2) step();
      chk("end_q32_empty", 64'(q32.size()), 64'd0);
      chk("end_q64_empty", 64'(q64.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
